// File: rtl/matmul_engine.sv
`default_nettype none
// ============================================================================
// Module   : matmul_engine
// Purpose  : Memory-mapped signed matrix multiply master (C = A*B); define
//            MATMUL_BIAS_EN to add a per-column bias before each C write.
// Revision : 1.0
// ============================================================================
module matmul_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int MAX_DIM    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = $clog2(MAX_DIM + 1);
  localparam int OFF_W = 2 * IDX_W + 1;
  localparam logic [ADDR_WIDTH-1:0] FLAG_ADDR = ADDR_WIDTH'(32'hA00);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_POLL     = 4'd1;
  localparam logic [3:0] ST_CFG      = 4'd2;
  localparam logic [3:0] ST_CHECK    = 4'd3;
  localparam logic [3:0] ST_RD_A     = 4'd4;
  localparam logic [3:0] ST_RD_B     = 4'd5;
  localparam logic [3:0] ST_MAC      = 4'd6;
  localparam logic [3:0] ST_WR       = 4'd7;
  localparam logic [3:0] ST_FLAG     = 4'd8;
`ifdef MATMUL_BIAS_EN
  localparam logic [3:0] ST_RD_BIAS  = 4'd9;
  localparam logic [3:0] ST_ADD_BIAS = 4'd10;
  localparam logic [2:0] CFG_LAST    = 3'd7;
`else
  localparam logic [2:0] CFG_LAST    = 3'd6;
`endif

  logic [3:0]                   state_q, state_d;
  logic [2:0]                   cfg_cnt_q, cfg_cnt_d;
  logic [ADDR_WIDTH-1:0]        a_base_q, a_base_d;
  logic [ADDR_WIDTH-1:0]        b_base_q, b_base_d;
  logic [ADDR_WIDTH-1:0]        c_base_q, c_base_d;
`ifdef MATMUL_BIAS_EN
  logic [ADDR_WIDTH-1:0]        bias_base_q, bias_base_d;
`endif
  logic [DATA_WIDTH-1:0]        m_q, m_d;
  logic [DATA_WIDTH-1:0]        n_q, n_d;
  logic [DATA_WIDTH-1:0]        p_q, p_d;
  logic [IDX_W-1:0]             i_q, i_d;
  logic [IDX_W-1:0]             j_q, j_d;
  logic [IDX_W-1:0]             k_q, k_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        a_val_q, a_val_d;
  logic                         err_q, err_d;
  logic                         poll_vld_q, poll_vld_d;
  logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]        mem_wdata_q, mem_wdata_d;
  logic                         mem_we_q, mem_we_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [IDX_W-1:0]             w_m_idx, w_n_idx, w_p_idx;
  logic signed [ACC_WIDTH-1:0]  w_a_ext, w_rd_ext, w_prod;
  logic                         w_last_i, w_last_j, w_last_k, w_dim_bad;

  function automatic logic [ADDR_WIDTH-1:0] cfg_addr(input logic [2:0] idx);
    logic [ADDR_WIDTH-1:0] a;
    case (idx)
      3'd0:    a = ADDR_WIDTH'(32'h000);
      3'd1:    a = ADDR_WIDTH'(32'h100);
      3'd2:    a = ADDR_WIDTH'(32'h200);
      3'd3:    a = ADDR_WIDTH'(32'h600);
      3'd4:    a = ADDR_WIDTH'(32'h700);
      3'd5:    a = ADDR_WIDTH'(32'h800);
`ifdef MATMUL_BIAS_EN
      3'd6:    a = ADDR_WIDTH'(32'hD00);
`endif
      default: a = FLAG_ADDR;
    endcase
    return a;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] idx_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [IDX_W-1:0]      row,
    input logic [IDX_W-1:0]      stride,
    input logic [IDX_W-1:0]      col
  );
    logic [OFF_W-1:0] off;
    off = OFF_W'(row) * OFF_W'(stride) + OFF_W'(col);
    return base + ADDR_WIDTH'(off);
  endfunction

  // Dimensions are range-checked before use, so their low bits suffice for indexing.
  assign w_m_idx   = m_q[IDX_W-1:0];
  assign w_n_idx   = n_q[IDX_W-1:0];
  assign w_p_idx   = p_q[IDX_W-1:0];
  assign w_last_i  = (i_q == w_m_idx - IDX_W'(1));
  assign w_last_j  = (j_q == w_p_idx - IDX_W'(1));
  assign w_last_k  = (k_q == w_n_idx - IDX_W'(1));
  assign w_dim_bad = (m_q == '0) || (m_q > DATA_WIDTH'(MAX_DIM)) ||
                     (n_q == '0) || (n_q > DATA_WIDTH'(MAX_DIM)) ||
                     (p_q == '0) || (p_q > DATA_WIDTH'(MAX_DIM));

  assign w_a_ext  = {{(ACC_WIDTH-DATA_WIDTH){a_val_q[DATA_WIDTH-1]}}, a_val_q};
  assign w_rd_ext = {{(ACC_WIDTH-DATA_WIDTH){mem_rdata[DATA_WIDTH-1]}}, mem_rdata};
  assign w_prod   = w_a_ext * w_rd_ext;

  always_comb begin
    state_d     = state_q;
    cfg_cnt_d   = cfg_cnt_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    c_base_d    = c_base_q;
`ifdef MATMUL_BIAS_EN
    bias_base_d = bias_base_q;
`endif
    m_d         = m_q;
    n_d         = n_q;
    p_d         = p_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    acc_d       = acc_q;
    a_val_d     = a_val_q;
    err_d       = err_q;
    // Right after reset the port address is 0, not the flag; that poll is discarded.
    poll_vld_d  = (state_q == ST_IDLE) && (mem_addr_q == FLAG_ADDR) && !mem_we_q;

    case (state_q)
      ST_IDLE: state_d = ST_POLL;
      ST_POLL: begin
        if (poll_vld_q && (mem_rdata == DATA_WIDTH'(1))) begin
          state_d   = ST_CFG;
          cfg_cnt_d = 3'd0;
          err_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CFG: begin
        case (cfg_cnt_q)
          3'd1:    a_base_d    = ADDR_WIDTH'(mem_rdata);
          3'd2:    b_base_d    = ADDR_WIDTH'(mem_rdata);
          3'd3:    c_base_d    = ADDR_WIDTH'(mem_rdata);
          3'd4:    m_d         = mem_rdata;
          3'd5:    n_d         = mem_rdata;
          3'd6:    p_d         = mem_rdata;
`ifdef MATMUL_BIAS_EN
          3'd7:    bias_base_d = ADDR_WIDTH'(mem_rdata);
`endif
          default: ;
        endcase
        if (cfg_cnt_q == CFG_LAST) begin
          state_d = ST_CHECK;
        end else begin
          cfg_cnt_d = cfg_cnt_q + 3'd1;
        end
      end
      ST_CHECK: begin
        if (w_dim_bad) begin
          err_d   = 1'b1;
          state_d = ST_FLAG;
        end else begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = ST_RD_A;
        end
      end
      ST_RD_A: state_d = ST_RD_B;
      ST_RD_B: begin
        a_val_d = mem_rdata;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d = acc_q + w_prod;
        if (w_last_k) begin
`ifdef MATMUL_BIAS_EN
          state_d = ST_RD_BIAS;
`else
          state_d = ST_WR;
`endif
        end else begin
          k_d     = k_q + IDX_W'(1);
          state_d = ST_RD_A;
        end
      end
`ifdef MATMUL_BIAS_EN
      ST_RD_BIAS: state_d = ST_ADD_BIAS;
      ST_ADD_BIAS: begin
        acc_d   = acc_q + w_rd_ext;
        state_d = ST_WR;
      end
`endif
      ST_WR: begin
        acc_d = '0;
        k_d   = '0;
        if (w_last_j) begin
          j_d = '0;
          if (w_last_i) begin
            state_d = ST_FLAG;
          end else begin
            i_d     = i_q + IDX_W'(1);
            state_d = ST_RD_A;
          end
        end else begin
          j_d     = j_q + IDX_W'(1);
          state_d = ST_RD_A;
        end
      end
      ST_FLAG: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Port outputs are registered: they carry the access belonging to the next state.
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    case (state_d)
      ST_IDLE, ST_POLL: mem_addr_d = FLAG_ADDR;
      ST_CFG:           mem_addr_d = cfg_addr(cfg_cnt_d);
      ST_RD_A:          mem_addr_d = idx_addr(a_base_q, i_d, w_n_idx, k_d);
      ST_RD_B:          mem_addr_d = idx_addr(b_base_q, k_d, w_p_idx, j_d);
`ifdef MATMUL_BIAS_EN
      ST_RD_BIAS:       mem_addr_d = bias_base_q + ADDR_WIDTH'(j_d);
`endif
      ST_WR: begin
        mem_addr_d  = idx_addr(c_base_q, i_d, w_p_idx, j_d);
        mem_wdata_d = acc_d[DATA_WIDTH-1:0];
        mem_we_d    = 1'b1;
      end
      ST_FLAG: begin
        mem_addr_d  = FLAG_ADDR;
        mem_wdata_d = err_d ? DATA_WIDTH'(2) : '0;
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_POLL);
    done_d = (state_d == ST_FLAG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_cnt_q   <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      c_base_q    <= '0;
`ifdef MATMUL_BIAS_EN
      bias_base_q <= '0;
`endif
      m_q         <= '0;
      n_q         <= '0;
      p_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      a_val_q     <= '0;
      err_q       <= 1'b0;
      poll_vld_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_cnt_q   <= cfg_cnt_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      c_base_q    <= c_base_d;
`ifdef MATMUL_BIAS_EN
      bias_base_q <= bias_base_d;
`endif
      m_q         <= m_d;
      n_q         <= n_d;
      p_q         <= p_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      a_val_q     <= a_val_d;
      err_q       <= err_d;
      poll_vld_q  <= poll_vld_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire
